// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch path: PC command encoding,
// word/address widths, fetch FSM states and the fetch queue entry layout.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  // {PC_load, PC_inc}
  localparam logic [1:0] PC_CLR  = 2'b00;
  localparam logic [1:0] PC_LD   = 2'b10;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b11;

  typedef enum logic [2:0] {
    CLEAR,
    WAIT,
    CAPTURE,
    STEP,
    IDLE,
    REDIR
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions tagged with their address.
// Flush wins over push and pop; a push on a full queue is accepted only
// when a pop frees the head in the same cycle.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [WORD_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_addr
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign do_pop  = pop & (cnt_q != 2'd0);
  assign do_push = push & ((cnt_q != 2'd2) | do_pop);

  // Pointer, count and storage update; flush simply rewinds the pointers.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = '{data: push_data, addr: push_addr};
        wr_d        = ~wr_q;
      end
      if (do_pop) begin
        rd_d = ~rd_q;
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Queue state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign count      = cnt_q;
  assign head_valid = (cnt_q != 2'd0);
  assign head_data  = mem_q[rd_q].data;
  assign head_addr  = mem_q[rd_q].addr;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: commands the PC, waits out PC and ROM
// latency, queues {instruction, address} pairs for decode and applies
// branch redirects from execute.
//
// state   | meaning
// --------+-------------------------------------------------------------
// CLEAR   | drive PC clear (00) for one cycle after reset
// WAIT    | hold PC, count down PC+ROM latency
// CAPTURE | hold PC, push ROM word and PC into queue once there is room
// STEP    | increment PC for one cycle
// IDLE    | fetching disabled, PC held
// REDIR   | load PC with the registered branch target for one cycle
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_LAT  = 2,
  parameter int ROM_LAT = 1,
  parameter int DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Fetch_en,
  output logic              PC_load,
  output logic              PC_inc,
  output logic [ADDR_W-1:0] Ins_addr,
  input  logic [ADDR_W-1:0] PC_addr,
  input  logic [WORD_W-1:0] ROM_data,
  input  logic              Br_taken,
  input  logic [ADDR_W-1:0] Br_target,
  output logic              Ins_valid,
  input  logic              Ins_ready,
  output logic [WORD_W-1:0] Ins_data,
  output logic [ADDR_W-1:0] Ins_pc
);

  // WAIT is entered with this value and exits after the cycle it reads 0,
  // so it lasts PC_LAT+ROM_LAT cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(PC_LAT + ROM_LAT - 1);

  fetch_state_t      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;
  logic [1:0]        pc_cmd;
  logic [1:0]        q_count;
  logic              q_full;
  logic              push, pop;

  assign q_full = (q_count == 2'(DEPTH));
  // Decode's handshake on a redirect cycle is void; the flush takes it.
  assign pop    = Ins_valid & Ins_ready & ~Br_taken;

  // Next-state, wait counter, PC command and push decision; a redirect
  // overrides whatever the current state would have done.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ins_addr_d = ins_addr_q;
    pc_cmd     = PC_HOLD;
    push       = 1'b0;
    case (state_q)
      CLEAR: begin
        pc_cmd  = PC_CLR;
        state_d = WAIT;
        cnt_d   = WAIT_LOAD;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        if (!q_full || pop) begin
          push    = 1'b1;
          state_d = Fetch_en ? STEP : IDLE;
        end
      end
      STEP: begin
        pc_cmd  = PC_INC;
        state_d = WAIT;
        cnt_d   = WAIT_LOAD;
      end
      IDLE: begin
        if (Fetch_en) state_d = STEP;
      end
      REDIR: begin
        pc_cmd  = PC_LD;
        state_d = WAIT;
        cnt_d   = WAIT_LOAD;
      end
      default: state_d = CLEAR;
    endcase
    if (Br_taken) begin
      state_d    = REDIR;
      ins_addr_d = Br_target;
      push       = 1'b0;
    end
  end

  // FSM, wait counter and load-target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= 4'd0;
      ins_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ins_addr_q <= ins_addr_d;
    end
  end

  assign {PC_load, PC_inc} = pc_cmd;
  assign Ins_addr          = ins_addr_q;

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (Br_taken),
    .push_data  (ROM_data),
    .push_addr  (PC_addr),
    .count      (q_count),
    .head_valid (Ins_valid),
    .head_data  (Ins_data),
    .head_addr  (Ins_pc)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC model (2-cycle command-to-address
// latency) and a ROM returning 0xA000+addr one cycle later.
// Cycle k is the cycle after the k-th rising edge following reset release;
// all checks and input changes happen on the falling edge.
module tb_fetch_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Fetch_en = 1'b1;
  logic        PC_load, PC_inc;
  logic [15:0] Ins_addr;
  logic [15:0] PC_addr, ROM_data;
  logic        Br_taken = 1'b0;
  logic [15:0] Br_target = 16'h0000;
  logic        Ins_valid;
  logic        Ins_ready = 1'b1;
  logic [15:0] Ins_data, Ins_pc;
  logic [1:0]  cmd;

  logic [15:0] pc_int  = 16'h1234;
  logic [15:0] pc_pipe = 16'h1234;
  logic [15:0] rom_q   = 16'h0000;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int inc_cnt;

  fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .Fetch_en  (Fetch_en),
    .PC_load   (PC_load),
    .PC_inc    (PC_inc),
    .Ins_addr  (Ins_addr),
    .PC_addr   (PC_addr),
    .ROM_data  (ROM_data),
    .Br_taken  (Br_taken),
    .Br_target (Br_target),
    .Ins_valid (Ins_valid),
    .Ins_ready (Ins_ready),
    .Ins_data  (Ins_data),
    .Ins_pc    (Ins_pc)
  );

  always #5 clk = ~clk;

  assign cmd      = {PC_load, PC_inc};
  assign PC_addr  = pc_pipe;
  assign ROM_data = rom_q;

  // PC and ROM model
  always @(posedge clk) begin
    case (cmd)
      PC_CLR:  pc_int <= 16'h0000;
      PC_LD:   pc_int <= Ins_addr;
      PC_INC:  pc_int <= pc_int + 16'h0001;
      default: ;
    endcase
    pc_pipe <= pc_int;
    rom_q   <= 16'hA000 + pc_pipe;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    Br_taken = 1'b0;
    #1;
    check("rst_valid", 16'(Ins_valid), 16'h0000);
    check("rst_cmd", 16'(cmd), 16'(PC_CLR));
    check("rst_ins_addr", Ins_addr, 16'h0000);
    check("rst_ins_data", Ins_data, 16'h0000);
    check("rst_ins_pc", Ins_pc, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Phase 1: first fetch latency and steady-state spacing
    do_reset();
    Ins_ready = 1'b1;
    Fetch_en  = 1'b1;
    check("p1_clear_cmd", 16'(cmd), 16'(PC_CLR));
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("p1_cmd", 16'(cmd), 16'((k % 5 == 0) ? PC_INC : PC_HOLD));
      check("p1_valid", 16'(Ins_valid), 16'(k % 5 == 0));
      if (k % 5 == 0) begin
        check("p1_data", Ins_data, 16'hA000 + 16'(k / 5 - 1));
        check("p1_pc", Ins_pc, 16'(k / 5 - 1));
      end
    end

    // Phase 2: decode stalled, queue fills, FSM parks in CAPTURE
    do_reset();
    Ins_ready = 1'b0;
    inc_cnt   = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (cmd == PC_INC) inc_cnt++;
      if (k >= 14) begin
        check("p2_stall_cmd", 16'(cmd), 16'(PC_HOLD));
        check("p2_stall_valid", 16'(Ins_valid), 16'h0001);
        check("p2_stall_data", Ins_data, 16'hA000);
        check("p2_stall_pc", Ins_pc, 16'h0000);
      end
    end
    check("p2_inc_count", 16'(inc_cnt), 16'd2);
    Ins_ready = 1'b1;
    tick();
    check("p2_r1_valid", 16'(Ins_valid), 16'h0001);
    check("p2_r1_data", Ins_data, 16'hA001);
    check("p2_r1_cmd", 16'(cmd), 16'(PC_INC));
    tick();
    check("p2_r2_valid", 16'(Ins_valid), 16'h0001);
    check("p2_r2_data", Ins_data, 16'hA002);
    check("p2_r2_pc", Ins_pc, 16'h0002);
    for (int k = 33; k <= 35; k++) begin
      tick();
      check("p2_gap_valid", 16'(Ins_valid), 16'h0000);
    end
    tick();
    check("p2_r3_valid", 16'(Ins_valid), 16'h0001);
    check("p2_r3_data", Ins_data, 16'hA003);
    check("p2_r3_pc", Ins_pc, 16'h0003);

    // Phase 3: redirect with a full queue
    do_reset();
    Ins_ready = 1'b0;
    run_to(20);
    check("p3_full_valid", 16'(Ins_valid), 16'h0001);
    Br_taken  = 1'b1;
    Br_target = 16'h0040;
    tick();
    Br_taken  = 1'b0;
    Br_target = 16'hDEAD;
    check("p3_flush_valid", 16'(Ins_valid), 16'h0000);
    check("p3_redir_cmd", 16'(cmd), 16'(PC_LD));
    check("p3_ins_addr", Ins_addr, 16'h0040);
    Ins_ready = 1'b1;
    for (int k = 22; k <= 25; k++) begin
      tick();
      check("p3_wait_valid", 16'(Ins_valid), 16'h0000);
    end
    tick();
    check("p3_tgt_valid", 16'(Ins_valid), 16'h0001);
    check("p3_tgt_pc", Ins_pc, 16'h0040);
    check("p3_tgt_data", Ins_data, 16'hA040);
    check("p3_addr_hold", Ins_addr, 16'h0040);

    // Phase 4: back-to-back redirects, newer target wins
    do_reset();
    Ins_ready = 1'b1;
    run_to(7);
    Br_taken  = 1'b1;
    Br_target = 16'h0010;
    tick();
    Br_target = 16'h0020;
    check("p4_redir1_cmd", 16'(cmd), 16'(PC_LD));
    check("p4_redir1_addr", Ins_addr, 16'h0010);
    tick();
    Br_taken = 1'b0;
    check("p4_redir2_cmd", 16'(cmd), 16'(PC_LD));
    check("p4_redir2_addr", Ins_addr, 16'h0020);
    check("p4_redir2_valid", 16'(Ins_valid), 16'h0000);
    for (int k = 10; k <= 13; k++) begin
      tick();
      check("p4_wait_valid", 16'(Ins_valid), 16'h0000);
    end
    tick();
    check("p4_tgt_valid", 16'(Ins_valid), 16'h0001);
    check("p4_tgt_pc", Ins_pc, 16'h0020);
    check("p4_tgt_data", Ins_data, 16'hA020);
    tick();
    check("p4_single_valid", 16'(Ins_valid), 16'h0000);

    // Phase 5: Fetch_en dropped mid-WAIT, then resumed
    do_reset();
    Ins_ready = 1'b1;
    run_to(7);
    Fetch_en = 1'b0;
    run_to(9);
    tick();
    check("p5_pend_valid", 16'(Ins_valid), 16'h0001);
    check("p5_pend_pc", Ins_pc, 16'h0001);
    check("p5_pend_data", Ins_data, 16'hA001);
    check("p5_idle_cmd0", 16'(cmd), 16'(PC_HOLD));
    for (int k = 11; k <= 19; k++) begin
      tick();
      check("p5_idle_valid", 16'(Ins_valid), 16'h0000);
      check("p5_idle_cmd", 16'(cmd), 16'(PC_HOLD));
      check("p5_idle_pcaddr", PC_addr, 16'h0001);
    end
    Fetch_en = 1'b1;
    tick();
    check("p5_resume_cmd", 16'(cmd), 16'(PC_INC));
    run_to(24);
    check("p5_resume_wait", 16'(Ins_valid), 16'h0000);
    tick();
    check("p5_next_valid", 16'(Ins_valid), 16'h0001);
    check("p5_next_pc", Ins_pc, 16'h0002);
    check("p5_next_data", Ins_data, 16'hA002);

    // Phase 6: address wrap at 0xFFFF
    do_reset();
    Ins_ready = 1'b1;
    run_to(7);
    Br_taken  = 1'b1;
    Br_target = 16'hFFFF;
    tick();
    Br_taken = 1'b0;
    run_to(12);
    tick();
    check("p6_top_valid", 16'(Ins_valid), 16'h0001);
    check("p6_top_pc", Ins_pc, 16'hFFFF);
    check("p6_top_data", Ins_data, 16'h9FFF);
    run_to(17);
    tick();
    check("p6_wrap_valid", 16'(Ins_valid), 16'h0001);
    check("p6_wrap_pc", Ins_pc, 16'h0000);
    check("p6_wrap_data", Ins_data, 16'hA000);

    // Phase 7: reset while an instruction is waiting, then refetch from 0
    do_reset();
    Ins_ready = 1'b0;
    run_to(8);
    check("p7_pre_valid", 16'(Ins_valid), 16'h0001);
    do_reset();
    Ins_ready = 1'b1;
    run_to(4);
    check("p7_refetch_wait", 16'(Ins_valid), 16'h0000);
    tick();
    check("p7_refetch_valid", 16'(Ins_valid), 16'h0001);
    check("p7_refetch_pc", Ins_pc, 16'h0000);
    check("p7_refetch_data", Ins_data, 16'hA000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
